// File: rtl/mul_pkg.sv
// Shared constants, response payload type and round-robin helper for the
// shared-multiplier arbiter.
package mul_pkg;

    localparam int unsigned MUL_W   = 8;
    localparam int unsigned MUL_PW  = 16;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned MAX_IDW = 3;

    typedef struct packed {
        logic [MAX_IDW-1:0] id;
        logic [MUL_PW-1:0]  p;
    } mul_rsp_t;

    // First requester with a pending request, searching from ptr+1 and wrapping
    // at nreq; returns ptr when nothing is requesting.
    function automatic logic [MAX_IDW-1:0] rr_next(
        input logic [MAX_IDW-1:0] ptr,
        input logic [MAX_REQ-1:0] req,
        input int unsigned        nreq
    );
        logic [MAX_IDW-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % nreq;
            if (k <= nreq && !found && req[MAX_IDW'(idx)]) begin
                grant = MAX_IDW'(idx);
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mul_core8.sv
// Combinational 8x8 unsigned array multiplier: sum of shifted partial products.
module mul_core8
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [MUL_PW-1:0] p
);

    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < MUL_W; i++) begin
            if (b[i]) begin
                p = p + (MUL_PW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter feeding one shared 8x8 multiplier through a two-stage
// pipeline, with a tagged, backpressured response channel.
module mul_share_arb
    import mul_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_p,
    output logic [15:0]         ops_done
);

    logic             v1;
    logic             v2;
    logic [IDW-1:0]   id1;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    mul_rsp_t         s2;
    logic [IDW-1:0]   ptr;

    logic             adv1;
    logic             adv2;
    logic             any_req;
    logic             accept;
    logic [IDW-1:0]   grant_idx;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic [MUL_PW-1:0] prod;

    assign adv2      = !v2 || rsp_ready;
    assign adv1      = !v1 || adv2;
    assign any_req   = |req_valid;
    assign accept    = any_req && adv1;
    assign grant_idx = IDW'(rr_next(MAX_IDW'(ptr), MAX_REQ'(req_valid), NREQ));

    // Grant and operand select; ready is gated by reset so it reads 0 while held.
    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                req_ready[i] = accept && rst_n;
                a_sel        = req_a[i*W +: W];
                b_sel        = req_b[i*W +: W];
            end
        end
    end

    mul_core8 u_core (
        .a (a1),
        .b (b1),
        .p (prod)
    );

    // Pipeline stages, round-robin pointer and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            id1      <= '0;
            a1       <= '0;
            b1       <= '0;
            v2       <= 1'b0;
            s2       <= '0;
            ptr      <= IDW'(NREQ - 1);
            ops_done <= '0;
        end else begin
            if (adv1) begin
                v1 <= accept;
                if (accept) begin
                    id1 <= grant_idx;
                    a1  <= a_sel;
                    b1  <= b_sel;
                    ptr <= grant_idx;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    s2.id <= MAX_IDW'(id1);
                    s2.p  <= prod;
                end
            end
            if (v2 && rsp_ready) begin
                ops_done <= ops_done + 16'd1;
            end
        end
    end

    assign rsp_valid = v2;
    assign rsp_id    = IDW'(s2.id);
    assign rsp_p     = s2.p;

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: reference round-robin/occupancy model
// plus an in-order scoreboard of expected {id, product} responses.
module tb_mul_share_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [2*W-1:0]      rsp_p;
    logic [15:0]         ops_done;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] sb[$];
    int mptr;
    logic [15:0] mcnt;

    mul_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model evaluated mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        int idx;
        if (!rst_n) begin
            sb.delete();
            mptr = NREQ - 1;
            mcnt = '0;
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_valid", 32'(rsp_valid), 32'd0);
            chk("rst_id",    32'(rsp_id),    32'd0);
            chk("rst_p",     32'(rsp_p),     32'd0);
            chk("rst_ops",   32'(ops_done),  32'd0);
        end else begin
            exp_rdy = '0;
            g = -1;
            if (|req_valid && (sb.size() < 2 || rsp_ready)) begin
                for (int k = 1; k <= int'(NREQ); k++) begin
                    idx = (mptr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                exp_rdy[g] = 1'b1;
            end
            chk("grant", 32'(req_ready), 32'(exp_rdy));
            chk("ops_done", 32'(ops_done), 32'(mcnt));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("stale_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp", (32'(rsp_id) << 16) | 32'(rsp_p), sb[0]);
                    if (rsp_ready) void'(sb.pop_front());
                end
                if (rsp_ready) mcnt = mcnt + 16'd1;
            end
            if (g >= 0) begin
                sb.push_back((32'(g) << 16) |
                             (32'(req_a[g*W +: W]) * 32'(req_b[g*W +: W])));
                mptr = g;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i] = 1'b1;
        @(negedge clk);
        while (!req_ready[i] && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("issue_timeout", 32'(n >= 50), 32'd0);
        step();
        req_valid[i] = 1'b0;
    endtask

    task automatic expect_p(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 32'(rsp_p), 32'(exp));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int vcnt;
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // single request, latency and counter
        step();
        req_valid[0] = 1'b1;
        req_a[7:0] = 8'h0C;
        req_b[7:0] = 8'h0A;
        @(negedge clk);
        chk("single_ready", 32'(req_ready[0]), 32'd1);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("single_early", 32'(rsp_valid), 32'd0);
        step();
        @(negedge clk);
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id",    32'(rsp_id),    32'd0);
        chk("single_p",     32'(rsp_p),     32'h0078);
        step();
        @(negedge clk);
        chk("single_ops", 32'(ops_done), 32'd1);

        // extremes
        issue(1, 8'hFF, 8'hFF);
        expect_p("x_ff_ff", 16'hFE01);
        issue(3, 8'h00, 8'd200);
        expect_p("x_0_200", 16'h0000);
        issue(0, 8'h01, 8'hFF);
        expect_p("x_1_ff", 16'h00FF);
        drain();

        // backpressure on requester 2
        step();
        rsp_ready = 1'b0;
        req_valid[2] = 1'b1;
        req_a[2*W +: W] = 8'd17;
        req_b[2*W +: W] = 8'd3;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (req_ready[2]) acc++;
            step();
            if (acc == 1) req_a[2*W +: W] = 8'd29;
        end
        @(negedge clk);
        chk("bp_full_ready", 32'(req_ready), 32'd0);
        chk("bp_accepts", 32'(acc), 32'd2);
        step();
        req_valid[2] = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // reset with two products in flight
        rsp_ready = 1'b0;
        issue(0, 8'd3, 8'd4);
        issue(1, 8'd5, 8'd6);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        rsp_ready = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) vcnt++;
        end
        chk("mid_rst_stale", 32'(vcnt), 32'd0);
        step();
        req_a[7:0]  = 8'd9;  req_b[7:0]  = 8'd9;
        req_a[15:8] = 8'd7;  req_b[15:8] = 8'd8;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("post_rst_first", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_second", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        drain();

        // fairness from a clean pointer
        rst_pulse();
        step();
        req_valid = 4'hF;
        req_a = $urandom;
        req_b = $urandom;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("fair_order", 32'(req_ready), 32'(1) << (c % 4));
            step();
            req_a = $urandom;
            req_b = $urandom;
        end
        req_valid = '0;
        drain();

        // counter wrap from zero
        rst_pulse();
        step();
        req_a[7:0] = 8'd2;
        req_b[7:0] = 8'd3;
        req_valid[0] = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 65536 && n < 70000) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            step();
            n++;
        end
        req_valid = '0;
        chk("wrap_accepts", 32'(acc), 32'd65536);
        drain();
        @(negedge clk);
        chk("wrap_ops", 32'(ops_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and 2-stage pipeline controller that shares one combinational 8x8 array multiplier among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request per cycle, registers the operands, and drives them through the multiplier core. It then returns the 16-bit product, tagged with the requester index, on a single shared response channel with backpressure.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 8: operand width. Fixed at 8 to match the multiplier core; product width is `2*W`.
- `IDW`, default 2: requester-ID width, equal to `$clog2(NREQ)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_ready`  out  NREQ  one-hot or zero; a request is accepted on a cycle where `req_valid[i] & req_ready[i]`.
- `req_a`  in  NREQ*W  flattened operand A; requester i occupies `[i*W +: W]`.
- `req_b`  in  NREQ*W  flattened operand B, same layout.
- `rsp_valid`  out  1  product valid.
- `rsp_ready`  in  1  consumer accepts the product.
- `rsp_id`  out  IDW  index of the requester that issued the product.
- `rsp_p`  out  2*W  product `a*b`, unsigned.
- `ops_done`  out  16  count of completed responses; wraps modulo 2^16.

## Operation
- Pipeline registers:
  - S1 holds `v1`, `id1`, `a1`, `b1`.
  - S2 holds `v2`, `id2`, `p2`.
  - `p2` is loaded from the multiplier core output for `a1`/`b1`.
- Advance rules, evaluated combinationally each cycle:
  - `adv2 = !v2 | rsp_ready`
  - `adv1 = !v1 | adv2`
  - S1 loads from the granted requester when `adv1`.
  - S2 loads from S1 when `adv2`.
- Grant:
  - Search starts at `(ptr+1) mod NREQ` and picks the first i with `req_valid[i]`.
  - `req_ready[i]` is asserted only for that i, and only when `adv1`.
  - `req_ready` never depends on `req_a`/`req_b`.
- Pointer: `ptr` is updated to the granted index only on an accepted handshake. With no request, `ptr` holds.
- Empty cycles: if S1 advances with no accepted request, `v1` goes 0. If S2 advances with `v1=0`, `v2` goes 0.
- Outputs: `rsp_valid=v2`, `rsp_id=id2`, `rsp_p=p2`. These hold stable while `rsp_valid & !rsp_ready`.
- `ops_done` increments on every `rsp_valid & rsp_ready`.
- Arithmetic: unsigned, full 16-bit product with no truncation. `255*255 = 0xFE01`.

## Timing
- Reset (asynchronous assert, synchronous release semantics on internal flops):
  - `v1=v2=0` and `rsp_valid=0`.
  - `rsp_id=0`, `rsp_p=0`, `ops_done=0`.
  - `ptr=NREQ-1`, so requester 0 has first priority.
  - `req_ready=0` is asserted while `rst_n=0`.
- Latency: a request accepted at edge N shows `rsp_valid=1` after edge N+1, i.e. 2 cycles, when not stalled.
- Throughput: 1 accept and 1 response per cycle with `rsp_ready` held high.
- Backpressure: with `rsp_ready=0` the pipeline holds at most 2 products. Once S1 and S2 are both full, `req_ready=0` until `rsp_ready` returns.
- A consumer draining S2 in the same cycle as a new accept is legal, and that cycle yields a full-rate transfer.
- Reset mid-operation: in-flight S1/S2 contents are discarded with no response. Requesters must re-issue.
- Requester rules:
  - A requester may drop `req_valid` without a handshake; the block tolerates it.
  - Requesters must hold `req_a`/`req_b` stable while `req_valid=1` and not accepted.

## Structure
- Shared package `mul_pkg`:
  - constants `MUL_W=8`, `MUL_PW=16`
  - typedef `mul_rsp_t` with fields id, p
  - function `rr_next(ptr, req)` returning the grant index.
- One sub-module: `mul_core8`, the existing combinational 8x8 array multiplier, instantiated once between S1 and S2. No other hierarchy.

## Test plan
- Single request: requester 0, `a=0x0C`, `b=0x0A`, `rsp_ready=1`. Require `req_ready[0]` in the same cycle, then `rsp_valid` 2 cycles later with `rsp_id=0`, `rsp_p=0x0078`, and `ops_done=1`.
- Fairness: all 4 requesters held valid for 8 cycles with `rsp_ready=1`. Grant order must be 0,1,2,3,0,1,2,3, one per cycle, and the responses must carry the matching IDs in that order.
- Extremes: `255*255`, `0*200`, and `1*255`. Require `0xFE01`, `0x0000`, and `0x00FF` respectively.
- Backpressure: requester 2 continuously valid, `rsp_ready=0` for 6 cycles. Require exactly 2 accepts, then `req_ready=0`, with `rsp_p`/`rsp_id` stable throughout. After `rsp_ready=1`, responses must drain in order with no loss or duplication.
- Reset mid-flight: two requests accepted, then `rst_n` pulsed low before the first response. Require `rsp_valid=0` immediately and no stale response afterwards. The next request from requesters 1 and 0 together must grant requester 0 first.
- Counter wrap: preload by running 65536 responses. Require `ops_done` to return to 0.
